itch_frame_assembler: RTL and testbench
=======================================

// Module: itch_frame_assembler
// PURPOSE
//   Upstream stage of the order parser. Collects a byte stream (UART/network RX side)
//   into one fixed 36-byte order frame. Presents it as nine 32-bit words plus a
//   one-cycle valid pulse. Resynchronises on bad type bytes and on stalled frames.
//   Keeps saturating counters for completed and dropped frames.
// PARAMETERS
//   REG_WIDTH       32    width of each output word; fixed at 32
//   MSG_BYTES       36    frame length in bytes; must equal 9*REG_WIDTH/8
//   TIMEOUT_CYCLES  1024  max idle cycles between bytes of one frame before abort
// PORTS
//   i_clk          in   1          clock; all logic on the rising edge
//   i_reset_n      in   1          asynchronous, active-low reset
//   i_byte_valid   in   1          i_byte is valid this cycle; no backpressure
//   i_byte         in   8          stream byte; frame byte 0 is sent first
//   o_reg_0..o_reg_8 out REG_WIDTH frame words; byte k goes to o_reg_(k/4)[8*(k%4)+:8]
//   o_data_valid   out  1          one-cycle pulse; o_reg_* hold a new complete frame
//   o_busy         out  1          high while a frame is partly assembled
//   o_msg_count    out  16         frames delivered; saturates at 16'hFFFF
//   o_drop_count   out  16         discarded bytes/frames; saturates at 16'hFFFF
// BEHAVIOUR
//   Reset (async assert, sync deassert upstream)
//   - All o_reg_*, o_data_valid, o_busy and both counters go to 0.
//   - State goes to IDLE; byte index and timer go to 0.
//   - Reset in the middle of a frame drops that partial frame and does not count it.
//   FSM states: IDLE, COLLECT.
//   IDLE, i_byte_valid set:
//   - Byte is 0x41 ('A'), 0x44 ('D') or 0x45 ('E'): store it as frame byte 0,
//     set index to 1, clear the timer, go to COLLECT.
//   - Any other byte: discard it and add 1 to o_drop_count. Stay in IDLE.
//   COLLECT, i_byte_valid set:
//   - Write the byte at the current index, add 1 to index, clear the timer.
//   - If this byte is index MSG_BYTES-1 (the last byte): on the next edge load all
//     o_reg_* from the assembly buffer, assert o_data_valid for exactly one cycle,
//     add 1 to o_msg_count, set index to 0, go to IDLE.
//   COLLECT, i_byte_valid clear:
//   - Add 1 to the timer.
//   - When the timer reaches TIMEOUT_CYCLES-1: abort the frame, add 1 to o_drop_count,
//     set index to 0, go to IDLE. No o_data_valid.
//   - If a byte arrives in the same cycle the timeout would fire, the byte wins
//     and the timer clears.
//   Datapath and timing
//   - The assembly buffer is separate from o_reg_*. o_reg_* change only on a
//     frame completion and are otherwise held, so the downstream block may sample
//     them at any time.
//   - Latency: last byte sampled at edge N -> o_data_valid high and o_reg_* updated
//     from edge N+1 until edge N+2.
//   - Back-to-back frames are supported. A type byte arriving in the cycle o_data_valid
//     is high is accepted as byte 0 of the next frame. Throughput is one byte per cycle.
//   - The type byte is not re-checked at completion; the downstream block decodes the type.
//   - o_busy is a registered output equal to (state == COLLECT).
//   - Counters saturate; they never wrap.
// TESTING
//   1. 'A' frame, byte k = k for k >= 1, byte 0 = 0x41, no gaps
//      -> o_reg_0=32'h03020141, o_reg_1=32'h07060504, o_reg_8=32'h23222120;
//         one o_data_valid pulse on the cycle after byte 35; o_msg_count=1.
//   2. Bytes 0x00, 0xFF, then a full 'D' frame
//      -> o_drop_count=2; frame delivered with o_reg_0[7:0]=8'h44; o_msg_count=1.
//   3. 'E' frame with i_byte_valid high only every 3rd cycle
//      -> same words as with no gaps; o_busy high from byte 0 until the pulse.
//   4. 10 bytes of an 'A' frame, then TIMEOUT_CYCLES idle cycles
//      -> o_drop_count=1, o_busy=0, no o_data_valid; the next full frame is delivered correctly.
//   5. Two frames back-to-back with no idle cycle
//      -> two o_data_valid pulses 36 cycles apart; o_reg_* match frame 2 after the second pulse.
//   6. i_reset_n pulsed low after byte 20
//      -> all outputs 0 immediately, without waiting for a clock edge; the following frame is
//         delivered cleanly; o_drop_count=0.

Source files
------------

// File: rtl/itch_frame_assembler.sv
// Assembles a byte stream into one 36-byte order frame, presented as nine 32-bit words.
// Words and valid appear one cycle after the last byte. No backpressure; bad type bytes and stalled frames are dropped.
module itch_frame_assembler #(
  parameter int REG_WIDTH      = 32,
  parameter int MSG_BYTES      = 36,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_byte_valid,
  input  logic [7:0]           i_byte,
  output logic [REG_WIDTH-1:0] o_reg_0,
  output logic [REG_WIDTH-1:0] o_reg_1,
  output logic [REG_WIDTH-1:0] o_reg_2,
  output logic [REG_WIDTH-1:0] o_reg_3,
  output logic [REG_WIDTH-1:0] o_reg_4,
  output logic [REG_WIDTH-1:0] o_reg_5,
  output logic [REG_WIDTH-1:0] o_reg_6,
  output logic [REG_WIDTH-1:0] o_reg_7,
  output logic [REG_WIDTH-1:0] o_reg_8,
  output logic                 o_data_valid,
  output logic                 o_busy,
  output logic [15:0]          o_msg_count,
  output logic [15:0]          o_drop_count
);

  localparam int IDX_W = $clog2(MSG_BYTES);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [TMR_W-1:0]       timer;
  logic                   load_pend;
  logic [MSG_BYTES*8-1:0] frame_buf;

  function automatic logic is_type(input logic [7:0] b);
    return (b == 8'h41) || (b == 8'h44) || (b == 8'h45);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      idx          <= '0;
      timer        <= '0;
      load_pend    <= 1'b0;
      frame_buf    <= '0;
      o_reg_0      <= '0;
      o_reg_1      <= '0;
      o_reg_2      <= '0;
      o_reg_3      <= '0;
      o_reg_4      <= '0;
      o_reg_5      <= '0;
      o_reg_6      <= '0;
      o_reg_7      <= '0;
      o_reg_8      <= '0;
      o_data_valid <= 1'b0;
      o_busy       <= 1'b0;
      o_msg_count  <= '0;
      o_drop_count <= '0;
    end else begin
      o_data_valid <= load_pend;
      load_pend    <= 1'b0;

      // Publish the frame completed last cycle; the buffer may already be taking
      // byte 0 of the next frame on this same edge, which only touches byte 0's old value.
      if (load_pend) begin
        o_reg_0     <= frame_buf[0*REG_WIDTH +: REG_WIDTH];
        o_reg_1     <= frame_buf[1*REG_WIDTH +: REG_WIDTH];
        o_reg_2     <= frame_buf[2*REG_WIDTH +: REG_WIDTH];
        o_reg_3     <= frame_buf[3*REG_WIDTH +: REG_WIDTH];
        o_reg_4     <= frame_buf[4*REG_WIDTH +: REG_WIDTH];
        o_reg_5     <= frame_buf[5*REG_WIDTH +: REG_WIDTH];
        o_reg_6     <= frame_buf[6*REG_WIDTH +: REG_WIDTH];
        o_reg_7     <= frame_buf[7*REG_WIDTH +: REG_WIDTH];
        o_reg_8     <= frame_buf[8*REG_WIDTH +: REG_WIDTH];
        o_msg_count <= sat_inc(o_msg_count);
      end

      case (state)
        IDLE: begin
          if (i_byte_valid) begin
            if (is_type(i_byte)) begin
              frame_buf[7:0] <= i_byte;
              idx            <= IDX_W'(1);
              timer          <= '0;
              state          <= COLLECT;
              o_busy         <= 1'b1;
            end else begin
              o_drop_count <= sat_inc(o_drop_count);
            end
          end
        end
        COLLECT: begin
          if (i_byte_valid) begin
            frame_buf[{idx, 3'b000} +: 8] <= i_byte;
            timer <= '0;
            if (idx == LAST_IDX) begin
              idx       <= '0;
              state     <= IDLE;
              o_busy    <= 1'b0;
              load_pend <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (timer == TMR_LAST) begin
            // Stream stalled too long mid-frame: give up and resync on the next type byte.
            idx          <= '0;
            timer        <= '0;
            state        <= IDLE;
            o_busy       <= 1'b0;
            o_drop_count <= sat_inc(o_drop_count);
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_itch_frame_assembler.sv
// Bench for itch_frame_assembler: directed frames, a byte-filter table and randomized
// traffic, all checked each cycle against a queue-based frame model.
module tb_itch_frame_assembler;

  localparam int T  = 1024;
  localparam int NB = 36;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bv = 1'b0;
  logic [7:0]  bt = 8'h00;
  logic [31:0] r0, r1, r2, r3, r4, r5, r6, r7, r8;
  logic        dv, busy;
  logic [15:0] mc, dc;

  itch_frame_assembler #(.REG_WIDTH(32), .MSG_BYTES(NB), .TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_byte_valid(bv), .i_byte(bt),
    .o_reg_0(r0), .o_reg_1(r1), .o_reg_2(r2), .o_reg_3(r3), .o_reg_4(r4),
    .o_reg_5(r5), .o_reg_6(r6), .o_reg_7(r7), .o_reg_8(r8),
    .o_data_valid(dv), .o_busy(busy), .o_msg_count(mc), .o_drop_count(dc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses[$];

  // Reference model: a partial frame is a queue of bytes, a finished one is an array.
  logic [7:0]  part[$];
  logic [7:0]  done_f[NB];
  logic [7:0]  frm[NB];
  int          idle;
  bit          pend;
  bit          m_valid;
  logic [31:0] m_reg[9];
  int          m_msg, m_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_type(input logic [7:0] b);
    return b == 8'h41 || b == 8'h44 || b == 8'h45;
  endfunction

  function automatic void model_reset();
    part.delete();
    idle = 0; pend = 0; m_valid = 0; m_msg = 0; m_drop = 0;
    for (int w = 0; w < 9; w++) m_reg[w] = '0;
  endfunction

  function automatic void model_edge(input bit v, input logic [7:0] b);
    m_valid = pend;
    if (pend) begin
      for (int w = 0; w < 9; w++)
        m_reg[w] = {done_f[4*w+3], done_f[4*w+2], done_f[4*w+1], done_f[4*w]};
      if (m_msg < 65535) m_msg++;
      pend = 0;
    end
    if (part.size() == 0) begin
      if (v) begin
        if (is_type(b)) begin
          part.push_back(b);
          idle = 0;
        end else if (m_drop < 65535) m_drop++;
      end
    end else if (v) begin
      part.push_back(b);
      idle = 0;
      if (part.size() == NB) begin
        for (int i = 0; i < NB; i++) done_f[i] = part[i];
        part.delete();
        pend = 1;
      end
    end else begin
      idle++;
      if (idle == T) begin
        part.delete();
        idle = 0;
        if (m_drop < 65535) m_drop++;
      end
    end
  endfunction

  task automatic cycle(input bit v, input logic [7:0] b);
    logic [31:0] dr[9];
    bv = v;
    bt = b;
    @(posedge clk);
    model_edge(v, b);
    cyc++;
    #1;
    dr = '{r0, r1, r2, r3, r4, r5, r6, r7, r8};
    chk("valid", {31'd0, dv}, {31'd0, m_valid});
    chk("busy", {31'd0, busy}, {31'd0, part.size() != 0});
    chk("msg_count", {16'd0, mc}, 32'(m_msg));
    chk("drop_count", {16'd0, dc}, 32'(m_drop));
    for (int w = 0; w < 9; w++) chk($sformatf("reg%0d", w), dr[w], m_reg[w]);
    if (dv) pulses.push_back(cyc);
  endtask

  task automatic send_frm(input int gap);
    for (int i = 0; i < NB; i++) begin
      cycle(1'b1, frm[i]);
      if (i != NB - 1) repeat (gap) cycle(1'b0, 8'h00);
    end
  endtask

  task automatic fill_frm(input logic [7:0] ty, input bit seq);
    frm[0] = ty;
    for (int k = 1; k < NB; k++) frm[k] = seq ? 8'(k) : 8'($urandom_range(0, 255));
  endtask

  task automatic chk_zero(input string tag);
    logic [31:0] dr[9];
    dr = '{r0, r1, r2, r3, r4, r5, r6, r7, r8};
    for (int w = 0; w < 9; w++) chk($sformatf("%s_reg%0d", tag, w), dr[w], 32'd0);
    chk({tag, "_valid"}, {31'd0, dv}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_msg"}, {16'd0, mc}, 32'd0);
    chk({tag, "_drop"}, {16'd0, dc}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] b;
    bit         acc;
  } filt_t;
  filt_t tbl[8];

  initial begin
    int np;
    tbl[0] = '{8'h00, 1'b0}; tbl[1] = '{8'h41, 1'b1}; tbl[2] = '{8'hFF, 1'b0};
    tbl[3] = '{8'h44, 1'b1}; tbl[4] = '{8'h40, 1'b0}; tbl[5] = '{8'h45, 1'b1};
    tbl[6] = '{8'h42, 1'b0}; tbl[7] = '{8'h61, 1'b0};

    model_reset();
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // 'A' frame, byte k = k, no gaps
    fill_frm(8'h41, 1'b1);
    send_frm(0);
    chk("t1_early_valid", {31'd0, dv}, 32'd0);
    cycle(1'b0, 8'h00);
    chk("t1_valid", {31'd0, dv}, 32'd1);
    chk("t1_reg0", r0, 32'h03020141);
    chk("t1_reg1", r1, 32'h07060504);
    chk("t1_reg8", r8, 32'h23222120);
    chk("t1_msg", {16'd0, mc}, 32'd1);
    cycle(1'b0, 8'h00);
    chk("t1_pulse_len", {31'd0, dv}, 32'd0);

    // two junk bytes, then a 'D' frame
    cycle(1'b1, 8'h00);
    cycle(1'b1, 8'hFF);
    fill_frm(8'h44, 1'b0);
    send_frm(0);
    cycle(1'b0, 8'h00);
    chk("t2_drop", {16'd0, dc}, 32'd2);
    chk("t2_type", {24'd0, r0[7:0]}, 32'h44);
    chk("t2_msg", {16'd0, mc}, 32'd2);

    // 'E' frame with a byte every third cycle
    fill_frm(8'h45, 1'b1);
    send_frm(2);
    cycle(1'b0, 8'h00);
    chk("t3_reg0", r0, 32'h03020145);
    chk("t3_reg1", r1, 32'h07060504);
    chk("t3_reg8", r8, 32'h23222120);

    // stall mid-frame past the timeout, then a clean frame
    fill_frm(8'h41, 1'b0);
    np = pulses.size();
    for (int i = 0; i < 10; i++) cycle(1'b1, frm[i]);
    repeat (T) cycle(1'b0, 8'h00);
    chk("t4_drop", {16'd0, dc}, 32'd3);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_no_pulse", 32'(pulses.size()), 32'(np));
    fill_frm(8'h44, 1'b0);
    send_frm(0);
    cycle(1'b0, 8'h00);
    chk("t4_recover_msg", {16'd0, mc}, 32'd4);
    chk("t4_recover_reg0", r0, {frm[3], frm[2], frm[1], frm[0]});

    // longest survivable gap: the byte on the cycle the timeout would fire wins
    fill_frm(8'h45, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, frm[i]);
    repeat (T - 1) cycle(1'b0, 8'h00);
    for (int i = 5; i < NB; i++) cycle(1'b1, frm[i]);
    cycle(1'b0, 8'h00);
    chk("gap_msg", {16'd0, mc}, 32'd5);
    chk("gap_drop", {16'd0, dc}, 32'd3);
    chk("gap_reg8", r8, {frm[35], frm[34], frm[33], frm[32]});

    // back-to-back frames
    pulses.delete();
    fill_frm(8'h41, 1'b0);
    send_frm(0);
    fill_frm(8'h44, 1'b0);
    send_frm(0);
    cycle(1'b0, 8'h00);
    chk("t5_pulses", 32'(pulses.size()), 32'd2);
    if (pulses.size() == 2) chk("t5_spacing", 32'(pulses[1] - pulses[0]), 32'd36);
    chk("t5_reg0", r0, {frm[3], frm[2], frm[1], frm[0]});
    chk("t5_reg4", r4, {frm[19], frm[18], frm[17], frm[16]});

    // type-byte filter table
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, tbl[i].b);
      chk($sformatf("filt_busy_%h", tbl[i].b), {31'd0, busy}, {31'd0, tbl[i].acc});
      if (tbl[i].acc) begin
        fill_frm(tbl[i].b, 1'b0);
        for (int k = 1; k < NB; k++) cycle(1'b1, frm[k]);
        cycle(1'b0, 8'h00);
        chk($sformatf("filt_valid_%h", tbl[i].b), {31'd0, dv}, 32'd1);
      end
    end

    // async reset after byte 20
    fill_frm(8'h41, 1'b0);
    for (int i = 0; i <= 20; i++) cycle(1'b1, frm[i]);
    bv = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero("t6_async");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    fill_frm(8'h45, 1'b0);
    send_frm(0);
    cycle(1'b0, 8'h00);
    chk("t6_valid", {31'd0, dv}, 32'd1);
    chk("t6_msg", {16'd0, mc}, 32'd1);
    chk("t6_drop", {16'd0, dc}, 32'd0);

    // randomized traffic: junk bytes, random gaps, random types
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) cycle(1'b1, 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 2)) cycle(1'b0, 8'h00);
      case ($urandom_range(0, 2))
        0: fill_frm(8'h41, 1'b0);
        1: fill_frm(8'h44, 1'b0);
        default: fill_frm(8'h45, 1'b0);
      endcase
      for (int i = 0; i < NB; i++) begin
        cycle(1'b1, frm[i]);
        if (i != NB - 1) repeat ($urandom_range(0, 3)) cycle(1'b0, 8'h00);
      end
    end
    repeat (3) cycle(1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
